// File: rtl/mem_arbiter_if.sv
// Signal bundle between the memory arbiter, its two requesters and the shared memory port.
// The arbiter connects through master; the requesters/memory side through slave.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [1:0]            if_size;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_done;

  logic                  ls_req;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [1:0]            ls_size;
  logic                  ls_rw;
  logic [DATA_WIDTH-1:0] ls_wdata;
  logic                  ls_wready;
  logic                  ls_rvalid;
  logic [DATA_WIDTH-1:0] ls_rdata;
  logic                  ls_done;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic [1:0]            mem_access_size;
  logic                  mem_rw;
  logic                  mem_enable;
  logic                  mem_busy;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport master (
    input  if_req, if_addr, if_size,
    input  ls_req, ls_addr, ls_size, ls_rw, ls_wdata,
    input  mem_busy, mem_data_out,
    output if_rvalid, if_rdata, if_done,
    output ls_wready, ls_rvalid, ls_rdata, ls_done,
    output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable
  );

  modport slave (
    output if_req, if_addr, if_size,
    output ls_req, ls_addr, ls_size, ls_rw, ls_wdata,
    output mem_busy, mem_data_out,
    input  if_rvalid, if_rdata, if_done,
    input  ls_wready, ls_rvalid, ls_rdata, ls_done,
    input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between instruction fetch and load/store for one shared memory,
// issuing 1/4/8/16-word transactions as single-word beats.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus
);
  localparam int unsigned BEAT_W = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, DRAIN = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_t;

  state_t                  state_q, state_d;
  owner_t                  owner_q, owner_d;
  owner_t                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [BEAT_W-1:0]       last_beat_q, last_beat_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic [BEAT_W-1:0]       rcnt_q, rcnt_d;
  logic                    rw_q, rw_d;
  logic [READ_LATENCY-1:0] rpipe_q, rpipe_d;

  function automatic logic [BEAT_W-1:0] last_beat_of(input logic [1:0] size);
    logic [BEAT_W-1:0] lb;
    unique case (size)
      2'b00:   lb = BEAT_W'(0);
      2'b01:   lb = BEAT_W'(3);
      2'b10:   lb = BEAT_W'(7);
      default: lb = BEAT_W'(15);
    endcase
    return lb;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      last_grant_q <= OWN_LS;
      base_q       <= '0;
      last_beat_q  <= '0;
      beat_q       <= '0;
      rcnt_q       <= '0;
      rw_q         <= 1'b0;
      rpipe_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      last_beat_q  <= last_beat_d;
      beat_q       <= beat_d;
      rcnt_q       <= rcnt_d;
      rw_q         <= rw_d;
      rpipe_q      <= rpipe_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    last_beat_d  = last_beat_q;
    beat_d       = beat_q;
    rcnt_d       = rcnt_q;
    rw_d         = rw_q;
    rpipe_d      = rpipe_q << 1;

    bus.mem_enable      = 1'b0;
    bus.mem_rw          = 1'b0;
    bus.mem_address     = '0;
    bus.mem_data_in     = '0;
    bus.mem_access_size = 2'b00;
    bus.ls_wready       = 1'b0;
    bus.ls_rvalid       = 1'b0;
    bus.ls_rdata        = '0;
    bus.ls_done         = 1'b0;
    bus.if_rvalid       = 1'b0;
    bus.if_rdata        = '0;
    bus.if_done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        // On a tie the requester that did not win last time is granted
        if (bus.if_req || bus.ls_req) begin
          owner_d      = (bus.if_req && (!bus.ls_req || last_grant_q == OWN_LS)) ? OWN_IF : OWN_LS;
          last_grant_d = owner_d;
          base_d       = ((owner_d == OWN_IF) ? bus.if_addr : bus.ls_addr) & ~ADDR_WIDTH'(3);
          last_beat_d  = last_beat_of((owner_d == OWN_IF) ? bus.if_size : bus.ls_size);
          rw_d         = (owner_d == OWN_IF) || bus.ls_rw;
          beat_d       = '0;
          rcnt_d       = '0;
          state_d      = BURST;
        end
      end
      BURST: begin
        bus.mem_enable  = 1'b1;
        bus.mem_rw      = rw_q;
        bus.mem_address = base_q + ADDR_WIDTH'({beat_q, 2'b00});
        bus.mem_data_in = rw_q ? '0 : bus.ls_wdata;
        if (!bus.mem_busy) begin
          beat_d = beat_q + BEAT_W'(1);
          if (rw_q) begin
            rpipe_d[0] = 1'b1;
            if (beat_q == last_beat_q) state_d = DRAIN;
          end else begin
            bus.ls_wready = 1'b1;
            if (beat_q == last_beat_q) begin
              bus.ls_done = 1'b1;
              state_d     = IDLE;
            end
          end
        end
      end
      DRAIN: state_d = state_q;
      default: state_d = IDLE;
    endcase

    // Read data returns a fixed latency after its accepted beat, even if later beats stall
    if (rpipe_q[READ_LATENCY-1]) begin
      rcnt_d = rcnt_q + BEAT_W'(1);
      if (owner_q == OWN_IF) begin
        bus.if_rvalid = 1'b1;
        bus.if_rdata  = bus.mem_data_out;
        bus.if_done   = (rcnt_q == last_beat_q);
      end else begin
        bus.ls_rvalid = 1'b1;
        bus.ls_rdata  = bus.mem_data_out;
        bus.ls_done   = (rcnt_q == last_beat_q);
      end
      if (rcnt_q == last_beat_q) state_d = IDLE;
    end

    if (reset) begin
      bus.mem_enable  = 1'b0;
      bus.mem_rw      = 1'b0;
      bus.mem_address = '0;
      bus.mem_data_in = '0;
      bus.ls_wready   = 1'b0;
      bus.ls_rvalid   = 1'b0;
      bus.ls_rdata    = '0;
      bus.ls_done     = 1'b0;
      bus.if_rvalid   = 1'b0;
      bus.if_rdata    = '0;
      bus.if_done     = 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level scoreboard checks the memory port and
// return channels every cycle, and each scenario pins its timing/addresses with literals.
module tb_mem_arbiter;
  localparam int RL = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(RL)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  // Memory: returns mem_f(address) RL cycles after each accepted read beat
  logic [31:0] mpipe [RL];
  always @(posedge clock) begin
    mpipe[0] <= (bus.mem_enable && !bus.mem_busy && bus.mem_rw) ? mem_f(bus.mem_address) : 32'h0;
    for (int i = 1; i < RL; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mem_data_out = mpipe[RL-1];

  // Scoreboard: expected beat addresses/data per granted transaction and due cycles for reads
  typedef struct { int due; logic [31:0] data; } rd_t;
  logic [31:0] aq [$];
  logic [31:0] wq [$];
  rd_t         rq [$];
  int   mcyc    = 0;
  int   m_left  = 0;
  logic m_busy  = 1'b0;
  logic m_owner = 1'b0;
  logic m_last  = 1'b1;
  logic m_rw    = 1'b0;

  always @(negedge clock) begin : model
    logic        busy0, rv_exp, if_done_exp, ls_done_exp, wr_exp, own;
    logic [31:0] rd_exp, a;
    logic [1:0]  sz;
    rd_t         r;
    int          n;
    mcyc++;
    if (reset) begin
      chk("rst_mem_enable",  32'(bus.mem_enable), 32'd0);
      chk("rst_mem_rw",      32'(bus.mem_rw), 32'd0);
      chk("rst_mem_address", bus.mem_address, 32'd0);
      chk("rst_mem_data_in", bus.mem_data_in, 32'd0);
      chk("rst_if_rvalid",   32'(bus.if_rvalid), 32'd0);
      chk("rst_if_rdata",    bus.if_rdata, 32'd0);
      chk("rst_if_done",     32'(bus.if_done), 32'd0);
      chk("rst_ls_rvalid",   32'(bus.ls_rvalid), 32'd0);
      chk("rst_ls_rdata",    bus.ls_rdata, 32'd0);
      chk("rst_ls_done",     32'(bus.ls_done), 32'd0);
      chk("rst_ls_wready",   32'(bus.ls_wready), 32'd0);
      m_busy = 1'b0;
      m_last = 1'b1;
      aq.delete();
      wq.delete();
      rq.delete();
    end else begin
      busy0 = m_busy;
      rv_exp = 1'b0; if_done_exp = 1'b0; ls_done_exp = 1'b0; wr_exp = 1'b0; rd_exp = 32'h0;
      if (rq.size() > 0 && rq[0].due == mcyc) begin
        rv_exp = 1'b1;
        rd_exp = rq[0].data;
        void'(rq.pop_front());
        m_left--;
        if (m_left == 0) begin
          if (m_owner) ls_done_exp = 1'b1; else if_done_exp = 1'b1;
          m_busy = 1'b0;
        end
      end
      chk("if_rvalid", 32'(bus.if_rvalid), 32'(rv_exp && !m_owner));
      chk("ls_rvalid", 32'(bus.ls_rvalid), 32'(rv_exp && m_owner));
      if (rv_exp) chk("rdata", m_owner ? bus.ls_rdata : bus.if_rdata, rd_exp);
      if (busy0 && aq.size() > 0) begin
        chk("mem_enable", 32'(bus.mem_enable), 32'd1);
        chk("mem_address", bus.mem_address, aq[0]);
        chk("mem_rw", 32'(bus.mem_rw), 32'(m_rw));
        if (!m_rw) chk("mem_data_in", bus.mem_data_in, wq[0]);
        if (!bus.mem_busy) begin
          if (!m_rw) begin
            wr_exp = 1'b1;
            void'(wq.pop_front());
            if (aq.size() == 1) begin
              ls_done_exp = 1'b1;
              m_busy = 1'b0;
            end
          end else begin
            r.due  = mcyc + RL;
            r.data = mem_f(aq[0]);
            rq.push_back(r);
          end
          void'(aq.pop_front());
        end
      end else begin
        chk("mem_enable_idle", 32'(bus.mem_enable), 32'd0);
      end
      chk("ls_wready", 32'(bus.ls_wready), 32'(wr_exp));
      chk("if_done", 32'(bus.if_done), 32'(if_done_exp));
      chk("ls_done", 32'(bus.ls_done), 32'(ls_done_exp));
      chk("mem_access_size", 32'(bus.mem_access_size), 32'd0);
      if (!busy0 && (bus.if_req || bus.ls_req)) begin
        own = (bus.if_req && (!bus.ls_req || m_last)) ? 1'b0 : 1'b1;
        a   = own ? bus.ls_addr : bus.if_addr;
        sz  = own ? bus.ls_size : bus.if_size;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 4 : (sz == 2'd2) ? 8 : 16;
        m_rw = own ? bus.ls_rw : 1'b1;
        for (int i = 0; i < n; i++) begin
          aq.push_back({a[31:2], 2'b00} + 32'(4 * i));
          if (!m_rw) wq.push_back(bus.ls_wdata + 32'(i));
        end
        m_left  = n;
        m_owner = own;
        m_last  = own;
        m_busy  = 1'b1;
      end
    end
  end

  // Observations for the per-scenario literal checks
  int          cyc = 0;
  int          if_done_cyc = -1, ls_done_cyc = -1, wready_cyc = -1;
  int          n_wready = 0, n_if_rv = 0;
  logic [31:0] obs_addr [$];
  logic [31:0] stall_addr [$];
  int          en_cyc [$];
  int          rv_cyc [$];
  int          done_order [$];

  task automatic clear_obs();
    obs_addr.delete(); stall_addr.delete(); en_cyc.delete(); rv_cyc.delete(); done_order.delete();
    n_wready = 0; n_if_rv = 0;
  endtask

  // One cycle: sample at negedge, then model the requesters after the rising edge
  task automatic step();
    logic wr, ld, idn;
    @(negedge clock);
    wr  = bus.ls_wready;
    ld  = bus.ls_done;
    idn = bus.if_done;
    if (bus.mem_enable) en_cyc.push_back(cyc);
    if (bus.mem_enable && !bus.mem_busy) obs_addr.push_back(bus.mem_address);
    if (bus.mem_enable && bus.mem_busy) stall_addr.push_back(bus.mem_address);
    if (bus.if_rvalid) begin n_if_rv++; rv_cyc.push_back(cyc); end
    if (wr) begin n_wready++; wready_cyc = cyc; end
    if (idn) begin done_order.push_back(0); if_done_cyc = cyc; end
    if (ld) begin done_order.push_back(1); ls_done_cyc = cyc; end
    @(posedge clock);
    #1;
    cyc++;
    if (wr)  bus.ls_wdata = bus.ls_wdata + 32'd1;
    if (ld)  bus.ls_req = 1'b0;
    if (idn) bus.if_req = 1'b0;
  endtask

  task automatic run_until_idle(input string name);
    int k = 0;
    while ((bus.if_req || bus.ls_req) && k < 200) begin
      step();
      k++;
    end
    chk({name, "_timeout"}, 32'(bus.if_req || bus.ls_req), 32'd0);
    step();
  endtask

  task automatic req_if(input logic [31:0] addr, input logic [1:0] size);
    bus.if_addr = addr; bus.if_size = size; bus.if_req = 1'b1;
  endtask

  task automatic req_ls(input logic [31:0] addr, input logic [1:0] size, input logic rw,
                        input logic [31:0] wdata);
    bus.ls_addr = addr; bus.ls_size = size; bus.ls_rw = rw; bus.ls_wdata = wdata; bus.ls_req = 1'b1;
  endtask

  initial begin
    int s, k;
    logic [31:0] exp4 [4];
    bus.if_req = 1'b0; bus.if_addr = '0; bus.if_size = 2'd0;
    bus.ls_req = 1'b0; bus.ls_addr = '0; bus.ls_size = 2'd0; bus.ls_rw = 1'b0; bus.ls_wdata = '0;
    bus.mem_busy = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset_state_enable", 32'(bus.mem_enable), 32'd0);
    chk("reset_state_done", 32'(bus.if_done || bus.ls_done), 32'd0);

    // Tie right after reset: fetch first, then LS on the IDLE cycle after if_done
    clear_obs();
    req_if(32'h0000_1000, 2'd0);
    req_ls(32'h0000_2000, 2'd0, 1'b0, 32'h11);
    s = cyc;
    run_until_idle("tie1");
    chk("tie1_if_done_cyc", 32'(if_done_cyc - s), 32'd2);
    chk("tie1_ls_done_cyc", 32'(ls_done_cyc - s), 32'd4);
    req_if(32'h0000_1004, 2'd0);
    req_ls(32'h0000_2004, 2'd0, 1'b0, 32'h22);
    run_until_idle("tie2");
    chk("tie_order_n", 32'(done_order.size()), 32'd4);
    chk("tie_order0", 32'(done_order[0]), 32'd0);
    chk("tie_order1", 32'(done_order[1]), 32'd1);
    chk("tie_order2", 32'(done_order[2]), 32'd0);
    chk("tie_order3", 32'(done_order[3]), 32'd1);

    // Single LS write
    clear_obs();
    req_ls(32'h8002_0000, 2'd0, 1'b0, 32'hDEAD_BEEF);
    s = cyc;
    run_until_idle("wr1");
    chk("wr1_naddr", 32'(obs_addr.size()), 32'd1);
    chk("wr1_addr", obs_addr[0], 32'h8002_0000);
    chk("wr1_wready_cyc", 32'(wready_cyc - s), 32'd1);
    chk("wr1_done_cyc", 32'(ls_done_cyc - s), 32'd1);

    // Fetch 4-word read
    clear_obs();
    req_if(32'h8002_0010, 2'd1);
    s = cyc;
    run_until_idle("rd4");
    exp4 = '{32'h8002_0010, 32'h8002_0014, 32'h8002_0018, 32'h8002_001C};
    chk("rd4_naddr", 32'(obs_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("rd4_addr%0d", i), obs_addr[i], exp4[i]);
    chk("rd4_first_beat", 32'(en_cyc[0] - s), 32'd1);
    chk("rd4_last_beat", 32'(en_cyc[3] - s), 32'd4);
    chk("rd4_first_rvalid", 32'(rv_cyc[0] - s), 32'd2);
    chk("rd4_nrvalid", 32'(n_if_rv), 32'd4);
    chk("rd4_done_cyc", 32'(if_done_cyc - s), 32'd5);

    // 8-word LS write without and with a 2-cycle stall on beat 2
    clear_obs();
    req_ls(32'h0000_0100, 2'd2, 1'b0, 32'h1000);
    s = cyc;
    run_until_idle("wr8");
    chk("wr8_done_cyc", 32'(ls_done_cyc - s), 32'd8);
    chk("wr8_nwready", 32'(n_wready), 32'd8);
    clear_obs();
    req_ls(32'h0000_0200, 2'd2, 1'b0, 32'h2000);
    s = cyc;
    k = 0;
    while (n_wready < 2 && k < 30) begin step(); k++; end
    chk("stall_reach", 32'(n_wready), 32'd2);
    bus.mem_busy = 1'b1;
    step();
    step();
    bus.mem_busy = 1'b0;
    run_until_idle("wr8s");
    chk("wr8s_done_cyc", 32'(ls_done_cyc - s), 32'd10);
    chk("wr8s_nwready", 32'(n_wready), 32'd8);
    chk("wr8s_nstall", 32'(stall_addr.size()), 32'd2);
    chk("wr8s_stall_addr0", stall_addr[0], 32'h0000_0208);
    chk("wr8s_stall_addr1", stall_addr[1], 32'h0000_0208);

    // Alignment and address wrap on an LS read
    clear_obs();
    req_ls(32'hFFFF_FFFE, 2'd1, 1'b1, 32'h0);
    run_until_idle("wrap");
    exp4 = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
    chk("wrap_naddr", 32'(obs_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_addr%0d", i), obs_addr[i], exp4[i]);
    chk("wrap_done", 32'(done_order.size()), 32'd1);

    // Reset during beat 3 of a 16-word fetch, then a fresh request
    clear_obs();
    req_if(32'h0000_3000, 2'd3);
    k = 0;
    while (obs_addr.size() < 3 && k < 30) begin step(); k++; end
    chk("mid_reach", 32'(obs_addr.size()), 32'd3);
    reset = 1'b1;
    bus.if_req = 1'b0;
    step();
    reset = 1'b0;
    chk("mid_enable_after", 32'(bus.mem_enable), 32'd0);
    clear_obs();
    for (int i = 0; i < 4; i++) step();
    chk("mid_no_enable", 32'(en_cyc.size()), 32'd0);
    chk("mid_no_rvalid", 32'(n_if_rv), 32'd0);
    chk("mid_no_done", 32'(done_order.size()), 32'd0);
    req_if(32'h0000_0044, 2'd0);
    run_until_idle("fresh");
    chk("fresh_naddr", 32'(obs_addr.size()), 32'd1);
    chk("fresh_addr", obs_addr[0], 32'h0000_0044);
    chk("fresh_done", 32'(done_order.size()), 32'd1);
    chk("fresh_rvalid", 32'(n_if_rv), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits between the instruction-fetch unit, the load/store unit and the single shared byte-addressed `memory` instance.
- Arbitrates between the two requesters round-robin and sequences 1/4/8/16-word transactions as back-to-back single-word beats on the memory port.
- Honours memory busy, returns read data to the owner and pulses done at transaction end.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, word width
READ_LATENCY, 1, cycles from an accepted read beat to valid mem_data_out (range 1..4)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_WIDTH  fetch base address
if_size  in  2  00=1, 01=4, 10=8, 11=16 words
if_rvalid  out  1  if_rdata valid this cycle
if_rdata  out  DATA_WIDTH  fetch read word
if_done  out  1  one-cycle end-of-transaction pulse
ls_req  in  1  load/store request, held until ls_done
ls_addr  in  ADDR_WIDTH  load/store base address
ls_size  in  2  same encoding as if_size
ls_rw  in  1  1=read, 0=write
ls_wdata  in  DATA_WIDTH  current write word
ls_wready  out  1  ls_wdata consumed this cycle; requester advances to next word
ls_rvalid  out  1  ls_rdata valid this cycle
ls_rdata  out  DATA_WIDTH  load read word
ls_done  out  1  one-cycle end-of-transaction pulse
mem_address  out  ADDR_WIDTH  to memory address
mem_data_in  out  DATA_WIDTH  to memory data_in
mem_access_size  out  2  always 2'b00
mem_rw  out  1  1=read, 0=write
mem_enable  out  1  beat valid
mem_busy  in  1  memory stall
mem_data_out  in  DATA_WIDTH  memory read data

Behaviour:
- States: IDLE, BURST, DRAIN.
- Reset: state=IDLE; last_grant=LS; beat counter=0; read-valid pipeline cleared.
  - All outputs are 0 during and after reset, including mem_enable, mem_rw, mem_address, every rvalid/rdata/done and ls_wready.
- Reset mid-transaction:
  - Abandon the transaction immediately; in-flight read data is discarded.
  - No done pulse is issued.
- IDLE arbitration:
  - If exactly one req is high, grant it.
  - If both are high, grant the requester that is not last_grant, so fetch wins the first tie after reset.
  - On grant, latch owner, base = addr with bits[1:0] forced to 0, beats N = 1/4/8/16 from size, and rw (fetch is always rw=1).
  - Update last_grant and go to BURST next cycle.
- BURST:
  - mem_enable=1, mem_rw=latched rw, mem_address = base + 4*beat (modulo 2^ADDR_WIDTH; wrap allowed), mem_access_size=00.
  - A beat is accepted when mem_enable && !mem_busy. Only accepted beats increment the beat counter.
  - On stall (mem_busy=1), address and data are held and ls_wready=0.
  - Writes: mem_data_in=ls_wdata; ls_wready=1 exactly on accepted beats.
    - On the accepted final beat, ls_done=1 in the same cycle; next state is IDLE.
  - Reads: each accepted beat pushes a valid bit into a READ_LATENCY-deep pipeline.
    - After the final accepted beat, go to DRAIN.
- Read return:
  - A pipeline bit at the output asserts owner rvalid=1 with rdata=mem_data_out that cycle.
  - The non-owner's rvalid stays 0; rdata outputs are don't-care when rvalid=0.
  - Owner done=1 in the same cycle as its Nth rvalid; next state is IDLE.
  - DRAIN drives mem_enable=0.
- Minimum of one IDLE cycle between transactions; a new grant may occur in that IDLE cycle.
- Requester changes to addr/size/rw while it owns the bus are ignored.
- Deasserting req mid-transaction does not abort it.

Test Plan:
- Single LS write: ls_addr=0x80020000, size=00, ls_wdata=0xDEADBEEF -> one mem_enable cycle with rw=0 at 0x80020000; ls_wready=1 and ls_done=1 in the same cycle.
- Fetch 4-word read (READ_LATENCY=1) at 0x80020010:
  - mem_address 0x..10, 0x..14, 0x..18, 0x..1C on consecutive cycles.
  - if_rvalid on 4 cycles, each one cycle behind its beat; if_done with the 4th.
- Simultaneous if_req and ls_req right after reset -> fetch granted first; LS granted on the IDLE cycle after if_done; a second simultaneous request then grants fetch again (alternation).
- mem_busy high for 2 cycles during beat 2 of an 8-word LS write:
  - Address and data are held and ls_wready=0 while stalled.
  - Exactly 8 wready pulses occur; ls_done comes 2 cycles later than in the unstalled case.
- Reset during beat 3 of a 16-word read -> next cycle mem_enable=0 and state is IDLE; no rvalid or done after reset; a fresh request completes correctly.
- Wrap and alignment: ls_addr=0xFFFFFFFE, size=01, read -> addresses 0xFFFFFFFC, 0x00000000, 0x00000004, 0x00000008.
